// File: rtl/pipeline_pkg.sv
// Shared constants and types for the arithmetic pipeline and its inverse divider.
package pipeline_pkg;

  localparam int unsigned PIPE_DW = 12;
  localparam int unsigned PIPE_VW = 4;

  // Quotient reported when the divisor is zero.
  localparam logic [PIPE_DW-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } inv_div_state_t;

endpackage

// File: rtl/pipeline_inv_div_if.sv
// Operand/result handshake bundle for pipeline_inv_div.
interface pipeline_inv_div_if
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = PIPE_DW,
  parameter int unsigned VW = PIPE_VW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] f_in;
  logic [VW-1:0] d_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] x3_out;
  logic [VW-1:0] rem_out;
  logic          div0;

  // Producer/consumer side.
  modport master (
    output in_valid, f_in, d_in, out_ready,
    input  in_ready, out_valid, x3_out, rem_out, div0
  );

  // Divider side.
  modport slave (
    input  in_valid, f_in, d_in, out_ready,
    output in_ready, out_valid, x3_out, rem_out, div0
  );

endinterface

// File: rtl/inv_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore.
module inv_div_step
  import pipeline_pkg::*;
#(
  parameter int unsigned VW = PIPE_VW
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   rem_o,
  output logic          q_o
);

  logic [VW+1:0] shifted;
  logic [VW:0]   diff;

  // Partial remainder stays below the divisor, so a kept difference fits VW+1 bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted[VW:0] - {1'b0, dvs_i};
    q_o     = (shifted >= (VW+2)'(dvs_i));
    rem_o   = q_o ? diff : shifted[VW:0];
  end

endmodule

// File: rtl/pipeline_inv_div.sv
// Iterative restoring divider recovering X3 = F / d from the arithmetic pipeline.
// Optional macro INV_DIV_EARLY_EXIT_EN: d == 1 and F < d finish in one cycle.
module pipeline_inv_div
  import pipeline_pkg::*;
#(
  parameter int unsigned DW = PIPE_DW,
  parameter int unsigned VW = PIPE_VW
) (
  input  logic               clk1,
  input  logic               rst,
  pipeline_inv_div_if.slave  bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  inv_div_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dvd_q, dvd_d;       // dividend bits shift out MSB, quotient bits shift in LSB
  logic [VW-1:0]  dvs_q, dvs_d;
  logic [VW:0]    prem_q, prem_d;
  logic [DW-1:0]  x3_q, x3_d;
  logic [VW-1:0]  rem_out_q, rem_out_d;
  logic           div0_q, div0_d;
  logic [VW:0]    step_rem;
  logic           step_q;

  inv_div_step #(.VW(VW)) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    x3_d      = x3_q;
    rem_out_d = rem_out_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d  = bus.f_in;
          dvs_d  = bus.d_in;
          prem_d = '0;
          cnt_d  = CW'(DW-1);
          if (bus.d_in == '0) begin
            state_d   = DONE;
            x3_d      = DW'(DIV0_QUOT);
            rem_out_d = bus.f_in[VW-1:0];
            div0_d    = 1'b1;
          end
`ifdef INV_DIV_EARLY_EXIT_EN
          else if (bus.d_in == VW'(1)) begin
            state_d   = DONE;
            x3_d      = bus.f_in;
            rem_out_d = '0;
            div0_d    = 1'b0;
          end
          else if (bus.f_in < DW'(bus.d_in)) begin
            state_d   = DONE;
            x3_d      = '0;
            rem_out_d = bus.f_in[VW-1:0];
            div0_d    = 1'b0;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[DW-2:0], step_q};
        prem_d = step_rem;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d   = DONE;
          x3_d      = {dvd_q[DW-2:0], step_q};
          rem_out_d = step_rem[VW-1:0];
          div0_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      x3_q      <= '0;
      rem_out_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      x3_q      <= x3_d;
      rem_out_q <= rem_out_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x3_out    = x3_q;
  assign bus.rem_out   = rem_out_q;
  assign bus.div0      = div0_q;

endmodule
